// File: rtl/time_pkg.sv
// Shared definitions for the time-of-day datapath: field selects, wrap limits,
// a wrap-around field adjust helper and the 12/24-hour display conversion.
package time_pkg;

    typedef enum logic [1:0] {
        SEL_SEC  = 2'd0,
        SEL_MIN  = 2'd1,
        SEL_HOUR = 2'd2,
        SEL_NONE = 2'd3
    } sel_e;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [4:0] HOUR_MAX = 5'd23;

    typedef struct packed {
        logic [4:0] hour;
        logic       pm;
    } disp_t;

    // Set-mode step of one field: wraps at both ends, no carry out.
    function automatic logic [5:0] adj_field(input logic [5:0] v, input logic [5:0] max,
                                             input logic up, input logic down);
        logic [5:0] r;
        r = v;
        if (up && !down)
            r = (v == max) ? 6'd0 : v + 6'd1;
        else if (down && !up)
            r = (v == 6'd0) ? max : v - 6'd1;
        return r;
    endfunction

    // 0 -> 12 AM, 1-11 AM, 12 -> 12 PM, 13-23 -> 1-11 PM.
    function automatic disp_t to_disp(input logic [4:0] hour, input logic mode_12h);
        disp_t d;
        d.hour = hour;
        d.pm   = 1'b0;
        if (mode_12h) begin
            if (hour == 5'd0)
                d.hour = 5'd12;
            else if (hour > 5'd12)
                d.hour = hour - 5'd12;
            d.pm = (hour >= 5'd12);
        end
        return d;
    endfunction

endpackage

// File: rtl/time_keeper_dp_tick_div.sv
// Clock divider: one-cycle tick on the last of every DIV enabled cycles.
// clr holds the count at zero so a release always starts a full period.
module tick_div #(
    parameter int DIV = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int             CW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  TERM = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en)
            cnt <= (cnt == TERM) ? '0 : cnt + 1'b1;
    end

    assign tick = en && !clr && (cnt == TERM);

endmodule

// File: rtl/time_keeper_dp.sv
// Time-of-day datapath: sub/sec/min/hour with same-edge carry chain, set-mode
// field editing and 12/24 h display. Alarm comparator built only with TIME_ALARM_EN.
module time_keeper_dp
    import time_pkg::*;
#(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int SUB_RATE  = 100,
    parameter int INIT_HOUR = 12,
    parameter int SUB_W     = $clog2(SUB_RATE)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_set,
    input  logic [1:0]       i_sel,
    input  logic             i_up,
    input  logic             i_down,
    input  logic             i_mode_12h,
    input  logic             i_alarm_wr,
    input  logic [4:0]       i_alarm_hour,
    input  logic [5:0]       i_alarm_min,
    input  logic             i_alarm_en,
    output logic [SUB_W-1:0] o_sub,
    output logic [5:0]       o_sec,
    output logic [5:0]       o_min,
    output logic [4:0]       o_hour,
    output logic [4:0]       o_hour_disp,
    output logic             o_pm,
    output logic             o_sec_tick,
    output logic             o_alarm
);
    localparam int               DIV     = CLK_FREQ / SUB_RATE;
    localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(SUB_RATE - 1);

    logic             sub_tick;
    logic [SUB_W-1:0] sub_d;
    logic [5:0]       sec_d, min_d;
    logic [4:0]       hour_d;
    logic             sec_tick_d;
    logic             sub_wrap, sec_wrap, min_wrap, hour_wrap;
    disp_t            disp;

    tick_div #(.DIV(DIV)) u_tick_div (
        .clk   (clk),
        .reset (reset),
        .en    (!i_set),
        .clr   (i_set),
        .tick  (sub_tick)
    );

    assign sub_wrap  = (o_sub == SUB_MAX);
    assign sec_wrap  = (o_sec == SEC_MAX);
    assign min_wrap  = (o_min == MIN_MAX);
    assign hour_wrap = (o_hour == HOUR_MAX);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        sub_d      = o_sub;
        sec_d      = o_sec;
        min_d      = o_min;
        hour_d     = o_hour;
        sec_tick_d = 1'b0;
        if (i_set) begin
            sub_d = '0;
            case (sel_e'(i_sel))
                SEL_SEC:  sec_d  = adj_field(o_sec, SEC_MAX, i_up, i_down);
                SEL_MIN:  min_d  = adj_field(o_min, MIN_MAX, i_up, i_down);
                SEL_HOUR: hour_d = 5'(adj_field({1'b0, o_hour}, {1'b0, HOUR_MAX}, i_up, i_down));
                default:  ;
            endcase
        end else if (sub_tick) begin
            sub_d = sub_wrap ? '0 : o_sub + 1'b1;
            if (sub_wrap) begin
                sec_tick_d = 1'b1;
                sec_d      = sec_wrap ? 6'd0 : o_sec + 6'd1;
                if (sec_wrap) begin
                    min_d = min_wrap ? 6'd0 : o_min + 6'd1;
                    if (min_wrap)
                        hour_d = hour_wrap ? 5'd0 : o_hour + 5'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_sub      <= '0;
            o_sec      <= '0;
            o_min      <= '0;
            o_hour     <= 5'(INIT_HOUR);
            o_sec_tick <= 1'b0;
        end else begin
            o_sub      <= sub_d;
            o_sec      <= sec_d;
            o_min      <= min_d;
            o_hour     <= hour_d;
            o_sec_tick <= sec_tick_d;
        end
    end

    assign disp        = to_disp(o_hour, i_mode_12h);
    assign o_hour_disp = disp.hour;
    assign o_pm        = disp.pm;

`ifdef TIME_ALARM_EN
    logic [4:0] alarm_hour_q;
    logic [5:0] alarm_min_q;
    logic       alarm_hit;

    // Only a run-mode seconds carry can land on hh:mm:00, so edits never fire it.
    assign alarm_hit = i_alarm_en && sec_tick_d && (sec_d == 6'd0) &&
                       (min_d == alarm_min_q) && (hour_d == alarm_hour_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            alarm_hour_q <= '0;
            alarm_min_q  <= '0;
            o_alarm      <= 1'b0;
        end else begin
            if (i_alarm_wr) begin
                alarm_hour_q <= i_alarm_hour;
                alarm_min_q  <= i_alarm_min;
            end
            o_alarm <= alarm_hit;
        end
    end
`else
    logic unused_alarm;
    assign unused_alarm = ^{i_alarm_wr, i_alarm_hour, i_alarm_min, i_alarm_en};
    assign o_alarm      = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper_dp.sv
// Self-checking bench for time_keeper_dp: time is modelled as a single count of
// sub-second units since midnight, advanced by elapsed run cycles.
module tb_time_keeper_dp;

    localparam int CLK_FREQ = 1000;
    localparam int SUB_RATE = 10;
    localparam int SUB_W    = $clog2(SUB_RATE);
    localparam int DIV      = CLK_FREQ / SUB_RATE;
    localparam int DAY      = 86400 * SUB_RATE;
    localparam int INIT_H   = 12;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             i_set = 1'b0;
    logic [1:0]       i_sel = 2'd3;
    logic             i_up = 1'b0;
    logic             i_down = 1'b0;
    logic             i_mode_12h = 1'b0;
    logic             i_alarm_wr = 1'b0;
    logic [4:0]       i_alarm_hour = '0;
    logic [5:0]       i_alarm_min = '0;
    logic             i_alarm_en = 1'b0;
    logic [SUB_W-1:0] o_sub;
    logic [5:0]       o_sec, o_min;
    logic [4:0]       o_hour, o_hour_disp;
    logic             o_pm, o_sec_tick, o_alarm;

    time_keeper_dp #(
        .CLK_FREQ  (CLK_FREQ),
        .SUB_RATE  (SUB_RATE),
        .INIT_HOUR (INIT_H)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .i_set        (i_set),
        .i_sel        (i_sel),
        .i_up         (i_up),
        .i_down       (i_down),
        .i_mode_12h   (i_mode_12h),
        .i_alarm_wr   (i_alarm_wr),
        .i_alarm_hour (i_alarm_hour),
        .i_alarm_min  (i_alarm_min),
        .i_alarm_en   (i_alarm_en),
        .o_sub        (o_sub),
        .o_sec        (o_sec),
        .o_min        (o_min),
        .o_hour       (o_hour),
        .o_hour_disp  (o_hour_disp),
        .o_pm         (o_pm),
        .o_sec_tick   (o_sec_tick),
        .o_alarm      (o_alarm)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: base time (sub units) plus run cycles elapsed since base.
    int base = INIT_H * 3600 * SUB_RATE;
    int rc = 0;
    int exp_tick = 0;
    int exp_alarm = 0;
    int al_h = 0;
    int al_m = 0;

    typedef struct {
        int hour;
        bit mode;
        int disp;
        bit pm;
    } vec_t;

    vec_t vecs[8];

    function automatic int cur();
        return (base + rc / DIV) % DAY;
    endfunction
    function automatic int hour_of(input int t); return t / (3600 * SUB_RATE); endfunction
    function automatic int min_of(input int t);  return (t / (60 * SUB_RATE)) % 60; endfunction
    function automatic int sec_of(input int t);  return (t / SUB_RATE) % 60; endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int t, h, d, p;
        t = cur();
        h = hour_of(t);
        d = h;
        p = 0;
        if (i_mode_12h) begin
            d = (h % 12 == 0) ? 12 : h % 12;
            p = (h >= 12) ? 1 : 0;
        end
        check("sub",      int'(o_sub),       t % SUB_RATE);
        check("sec",      int'(o_sec),       sec_of(t));
        check("min",      int'(o_min),       min_of(t));
        check("hour",     int'(o_hour),      h);
        check("hour_disp", int'(o_hour_disp), d);
        check("pm",       int'(o_pm),        p);
        check("sec_tick", int'(o_sec_tick),  exp_tick);
        check("alarm",    int'(o_alarm),     exp_alarm);
    endtask

    // One clock edge: advance the model with the inputs seen at the edge, then compare.
    task automatic cycle();
        int old_t, new_t, h, m, s;
        @(posedge clk);
        old_t = cur();
        exp_alarm = 0;
        if (i_set) begin
            h = hour_of(old_t);
            m = min_of(old_t);
            s = sec_of(old_t);
            if (i_up != i_down) begin
                case (i_sel)
                    2'd0: s = (s + (i_up ? 1 : 59)) % 60;
                    2'd1: m = (m + (i_up ? 1 : 59)) % 60;
                    2'd2: h = (h + (i_up ? 1 : 23)) % 24;
                    default: ;
                endcase
            end
            base = ((h * 60 + m) * 60 + s) * SUB_RATE;
            rc = 0;
            exp_tick = 0;
        end else begin
            rc++;
            new_t = cur();
            exp_tick = (new_t / SUB_RATE != old_t / SUB_RATE) ? 1 : 0;
`ifdef TIME_ALARM_EN
            if (i_alarm_en && exp_tick == 1 && new_t % (60 * SUB_RATE) == 0 &&
                hour_of(new_t) == al_h && min_of(new_t) == al_m)
                exp_alarm = 1;
`endif
        end
`ifdef TIME_ALARM_EN
        if (i_alarm_wr) begin
            al_h = int'(i_alarm_hour);
            al_m = int'(i_alarm_min);
        end
`endif
        #1;
        compare_all();
    endtask

    task automatic model_reset();
        base = INIT_H * 3600 * SUB_RATE;
        rc = 0;
        exp_tick = 0;
        exp_alarm = 0;
        al_h = 0;
        al_m = 0;
    endtask

    task automatic press(input logic [1:0] sel, input int n);
        i_sel = sel;
        for (int k = 0; k < n; k++) begin
            i_up = 1'b1;
            cycle();
            i_up = 1'b0;
        end
    endtask

    // Leaves the DUT in set mode showing h:m:s.0.
    task automatic set_time(input int h, input int m, input int s);
        i_set = 1'b1;
        i_up = 1'b0;
        i_down = 1'b0;
        i_sel = 2'd3;
        cycle();
        press(2'd2, (h - hour_of(cur()) + 24) % 24);
        press(2'd1, (m - min_of(cur()) + 60) % 60);
        press(2'd0, (s - sec_of(cur()) + 60) % 60);
        i_sel = 2'd3;
    endtask

    task automatic run(input int n);
        i_set = 1'b0;
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Runs until o_sec_tick, bounded; returns cycles taken or -1 on timeout.
    task automatic run_to_tick(input int limit, output int n);
        i_set = 1'b0;
        n = -1;
        for (int k = 1; k <= limit; k++) begin
            cycle();
            if (o_sec_tick) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic run_count_alarm(input int n, output int pulses, output int at);
        i_set = 1'b0;
        pulses = 0;
        at = 0;
        for (int k = 1; k <= n; k++) begin
            cycle();
            if (o_alarm) begin
                pulses++;
                at = k;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, pulses, at, exp_pulses, exp_at;

        vecs[0] = '{hour: 0,  mode: 1'b1, disp: 12, pm: 1'b0};
        vecs[1] = '{hour: 12, mode: 1'b1, disp: 12, pm: 1'b1};
        vecs[2] = '{hour: 15, mode: 1'b1, disp: 3,  pm: 1'b1};
        vecs[3] = '{hour: 15, mode: 1'b0, disp: 15, pm: 1'b0};
        vecs[4] = '{hour: 11, mode: 1'b1, disp: 11, pm: 1'b0};
        vecs[5] = '{hour: 23, mode: 1'b1, disp: 11, pm: 1'b1};
        vecs[6] = '{hour: 1,  mode: 1'b1, disp: 1,  pm: 1'b0};
        vecs[7] = '{hour: 0,  mode: 1'b0, disp: 0,  pm: 1'b0};

        // Reset state
        #12;
        compare_all();
        #1 reset = 1'b0;

        // First second after reset
        run_to_tick(1100, n);
        check("first_tick_cycle", n, 1000);
        check("t1_hour", int'(o_hour), 12);
        check("t1_min",  int'(o_min), 0);
        check("t1_sec",  int'(o_sec), 1);
        check("t1_sub",  int'(o_sub), 0);

        // Set-mode wraps without neighbour carry
        set_time(5, 59, 30);
        i_sel = 2'd1; i_up = 1'b1; cycle(); i_up = 1'b0;
        check("min_up_wrap", int'(o_min), 0);
        check("min_up_hour", int'(o_hour), 5);
        set_time(0, 10, 20);
        i_sel = 2'd2; i_down = 1'b1; cycle(); i_down = 1'b0;
        check("hour_down_wrap", int'(o_hour), 23);
        check("hour_down_min", int'(o_min), 10);
        i_sel = 2'd0; i_up = 1'b1; i_down = 1'b1; cycle(); i_up = 1'b0; i_down = 1'b0;
        check("up_down_sec", int'(o_sec), 20);
        i_sel = 2'd3; i_up = 1'b1; cycle(); i_up = 1'b0;
        check("sel_none_sec", int'(o_sec), 20);

        // Full rollover 23:59:59.9 -> 00:00:00.0
        set_time(23, 59, 59);
        run(900);
        check("pre_roll_sub", int'(o_sub), 9);
        run_to_tick(200, n);
        check("roll_cycle", n, 100);
        check("roll_hour", int'(o_hour), 0);
        check("roll_min",  int'(o_min), 0);
        check("roll_sec",  int'(o_sec), 0);
        check("roll_sub",  int'(o_sub), 0);

        // 12/24 h display table
        foreach (vecs[i]) begin
            set_time(vecs[i].hour, 0, 0);
            i_mode_12h = vecs[i].mode;
            #1;
            check($sformatf("disp_%0d", i), int'(o_hour_disp), vecs[i].disp);
            check($sformatf("pm_%0d", i),   int'(o_pm), int'(vecs[i].pm));
        end
        i_mode_12h = 1'b0;

`ifdef TIME_ALARM_EN
        exp_pulses = 1;
        exp_at = 1000;
`else
        exp_pulses = 0;
        exp_at = 0;
`endif
        // Alarm armed at 12:01
        set_time(12, 0, 59);
        i_alarm_hour = 5'd12; i_alarm_min = 6'd1; i_alarm_wr = 1'b1;
        cycle();
        i_alarm_wr = 1'b0;
        i_alarm_en = 1'b1;
        run_count_alarm(1050, pulses, at);
        check("alarm_armed_pulses", pulses, exp_pulses);
        check("alarm_armed_cycle", at, exp_at);
        // Disarmed
        set_time(12, 0, 59);
        i_alarm_en = 1'b0;
        run_count_alarm(1050, pulses, at);
        check("alarm_disarmed_pulses", pulses, 0);

        // Asynchronous reset at 12:34:56.7
        set_time(12, 34, 56);
        run(700);
        check("pre_reset_sub", int'(o_sub), 7);
        check("pre_reset_sec", int'(o_sec), 56);
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        #1 reset = 1'b0;
        run_to_tick(1100, n);
        check("post_reset_tick_cycle", n, 1000);
        check("post_reset_hour", int'(o_hour), 12);
        check("post_reset_sec",  int'(o_sec), 1);

        // Randomised traffic against the model
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(199) == 0) i_set = ~i_set;
            i_sel      = 2'($urandom_range(3));
            i_up       = ($urandom_range(3) == 0);
            i_down     = ($urandom_range(3) == 0);
            i_alarm_en = ($urandom_range(1) == 0);
            i_alarm_wr = ($urandom_range(99) == 0);
            i_alarm_hour = 5'($urandom_range(23));
            i_alarm_min  = 6'($urandom_range(59));
            if ($urandom_range(49) == 0) i_mode_12h = ~i_mode_12h;
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
